// File: rtl/cd_cdd_core.sv
// -----------------------------------------------------------------------------
// cd_cdd_core
//
// Command interpreter and status generator behind the CDD 4-bit bus engine.
// Each 10-nibble command frame from the host is checksum-validated and
// executed against the drive state machine. The BCD MSF play position advances
// at 75 frames/s. TOC queries are answered from static disc info or through a
// request/ack handshake with the image loader. Every result is packed into a
// 10-nibble status word for the bus engine to send on the next IRQ.
//
// Nibble n of a frame sits at bits [4n+3:4n]:
//   n0 code, n1 report, n2..n7 MSF digits (M tens first), n8 flags, n9 checksum.
//
// Ports
//   clk_sys        system clock
//   RESET          asynchronous, active-high reset
//   COMMAND_DATA   command frame, valid with COMMAND_SEND
//   COMMAND_SEND   one-cycle command strobe; ignored while a command is in flight
//   STATUS_OUT     status frame, updated with STATUS_LATCH
//   STATUS_LATCH   one-cycle strobe, at most one every three cycles
//   TOC_FIRST/LAST BCD first/last track
//   LEADOUT_MSF    BCD lead-out position {M,S,F}
//   TOC_REQ        level request for a track start; TOC_TRACK is held while high
//   TOC_TRACK      BCD track number being requested
//   TOC_ACK        one-cycle strobe, TOC_START_MSF/TOC_TYPE valid
//   TOC_START_MSF  BCD track start {M,S,F}
//   TOC_TYPE       track type
//   CUR_MSF        BCD absolute position
//   PLAYING        high while in the PLAYING state
//
// SEEK_FRAMES must be at least 1.
// -----------------------------------------------------------------------------
module cd_cdd_core #(
    parameter int CLK_HZ      = 48000000,
    parameter int SEEK_FRAMES = 8
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic [39:0] COMMAND_DATA,
    input  logic        COMMAND_SEND,
    output logic [39:0] STATUS_OUT,
    output logic        STATUS_LATCH,
    input  logic [7:0]  TOC_FIRST,
    input  logic [7:0]  TOC_LAST,
    input  logic [23:0] LEADOUT_MSF,
    output logic        TOC_REQ,
    output logic [7:0]  TOC_TRACK,
    input  logic        TOC_ACK,
    input  logic [23:0] TOC_START_MSF,
    input  logic [3:0]  TOC_TYPE,
    output logic [23:0] CUR_MSF,
    output logic        PLAYING
);

    localparam logic [31:0] DIV_TC    = 32'(CLK_HZ / 75 - 1);
    localparam logic [7:0]  SEEK_LAST = 8'(SEEK_FRAMES - 1);

    // Encodings double as the status code reported in n0.
    typedef enum logic [3:0] {
        ST_STOPPED   = 4'd0,
        ST_PLAYING   = 4'd1,
        ST_SEEKING   = 4'd2,
        ST_PAUSED    = 4'd4,
        ST_TRAY_OPEN = 4'd5
    } state_t;

    // ~(sum of n0..n8) mod 16
    function automatic logic [3:0] chk_nib(input logic [35:0] w);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 0; i < 9; i++) s = s + w[4*i +: 4];
        return ~s;
    endfunction

    // Two-digit BCD increment, 99 wraps to 00.
    function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
        if (v == 8'h99)        return 8'h00;
        if (v[3:0] == 4'h9)    return {v[7:4] + 4'h1, 4'h0};
        return {v[7:4], v[3:0] + 4'h1};
    endfunction

    // One frame forward: F 74 -> 00 carries into S, S 59 -> 00 carries into M.
    function automatic logic [23:0] msf_inc(input logic [23:0] m);
        logic [23:0] r;
        r = m;
        if (m[7:0] == 8'h74) begin
            r[7:0] = 8'h00;
            if (m[15:8] == 8'h59) begin
                r[15:8]  = 8'h00;
                r[23:16] = bcd2_inc(m[23:16]);
            end else begin
                r[15:8] = bcd2_inc(m[15:8]);
            end
        end else begin
            r[7:0] = bcd2_inc(m[7:0]);
        end
        return r;
    endfunction

    // n8..n0 of a status word; MSF digits go most-significant first into n2..n7.
    function automatic logic [35:0] pack_status(input logic [3:0]  code,
                                                input logic [3:0]  rpt,
                                                input logic [23:0] msf,
                                                input logic [3:0]  flags);
        return {flags, msf[3:0], msf[7:4], msf[11:8], msf[15:12],
                msf[19:16], msf[23:20], rpt, code};
    endfunction

    logic [31:0] div_cnt;
    logic        tick_raw;
    logic        tick_pend;
    logic        tick_go;
    logic        accept;
    logic        busy_pipe;

    logic        vld_p0;
    logic [31:0] cmd_p0;
    logic        cmd_ok_p0;

    state_t      state_q, state_d;
    logic [23:0] cur_q, cur_d;
    logic [7:0]  seek_cnt_q, seek_cnt_d;
    logic        land_play_q, land_play_d;
    logic        toc_req_q, toc_req_d;
    logic [7:0]  toc_track_q, toc_track_d;
    logic        vld_p1, vld_p1_d;
    logic [35:0] stat_p1, stat_p1_d;
    logic        tick_emit;
    logic [23:0] tgt_msf;
    logic [23:0] cur_inc;

    logic        vld_p2;

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET)                 div_cnt <= '0;
        else if (div_cnt == DIV_TC) div_cnt <= '0;
        else                       div_cnt <= div_cnt + 32'd1;
    end

    assign tick_raw  = (div_cnt == DIV_TC);
    assign busy_pipe = vld_p0 | vld_p1 | vld_p2;
    assign accept    = COMMAND_SEND & ~busy_pipe & ~toc_req_q;
    // A tick waits while a command owns the pipeline, so the command's status
    // latches first and the tick lands the cycle after that latch.
    assign tick_go   = (tick_raw | tick_pend) & ~busy_pipe & ~accept;

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) tick_pend <= 1'b0;
        else       tick_pend <= (tick_raw | tick_pend) & ~tick_go;
    end

    // ---- stage p0: capture and checksum decode ----
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) vld_p0 <= 1'b0;
        else       vld_p0 <= accept;
    end

    always_ff @(posedge clk_sys) begin
        if (accept) begin
            cmd_p0    <= COMMAND_DATA[31:0];
            cmd_ok_p0 <= (COMMAND_DATA[39:36] == chk_nib(COMMAND_DATA[35:0]));
        end
    end

    // ---- stage p1: drive state machine and status pack ----
    assign tgt_msf = {cmd_p0[11:8], cmd_p0[15:12], cmd_p0[19:16],
                      cmd_p0[23:20], cmd_p0[27:24], cmd_p0[31:28]};
    assign cur_inc = msf_inc(cur_q);

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        seek_cnt_d  = seek_cnt_q;
        land_play_d = land_play_q;
        toc_req_d   = toc_req_q;
        toc_track_d = toc_track_q;
        vld_p1_d    = 1'b0;
        stat_p1_d   = stat_p1;
        tick_emit   = 1'b0;

        if (vld_p0) begin
            vld_p1_d = 1'b1;
            if (!cmd_ok_p0) begin
                stat_p1_d = pack_status(state_q, 4'h0, cur_q, 4'h1);
            end else begin
                case (cmd_p0[3:0])
                    4'd1: begin
                        state_d = ST_STOPPED;
                        cur_d   = '0;
                    end
                    4'd3, 4'd4: begin
                        state_d     = ST_SEEKING;
                        cur_d       = tgt_msf;
                        seek_cnt_d  = '0;
                        land_play_d = (cmd_p0[3:0] == 4'd3);
                    end
                    4'd6:  if (state_q == ST_PLAYING)   state_d = ST_PAUSED;
                    4'd7:  if (state_q == ST_PAUSED)    state_d = ST_PLAYING;
                    4'd12: if (state_q == ST_TRAY_OPEN) state_d = ST_STOPPED;
                    4'd13: state_d = ST_TRAY_OPEN;
                    default: ;
                endcase
                stat_p1_d = pack_status(state_d, 4'h0, cur_d, 4'h0);
                if (cmd_p0[3:0] == 4'd2) begin
                    case (cmd_p0[7:4])
                        4'd3: stat_p1_d = pack_status(state_q, 4'd3, LEADOUT_MSF, 4'h0);
                        4'd4: stat_p1_d = pack_status(state_q, 4'd4,
                                                      {TOC_FIRST, TOC_LAST, 8'h00}, 4'h0);
                        4'd5: begin
                            // Reply is deferred until the loader acks.
                            vld_p1_d    = 1'b0;
                            toc_req_d   = 1'b1;
                            toc_track_d = {cmd_p0[11:8], cmd_p0[15:12]};
                        end
                        default: stat_p1_d = pack_status(state_q, cmd_p0[7:4], 24'h0, 4'h0);
                    endcase
                end
            end
        end else if (toc_req_q && TOC_ACK) begin
            toc_req_d = 1'b0;
            vld_p1_d  = 1'b1;
            stat_p1_d = pack_status(state_q, 4'd5, TOC_START_MSF, TOC_TYPE);
        end

        if (tick_go) begin
            case (state_q)
                ST_SEEKING: begin
                    if (seek_cnt_q == SEEK_LAST) begin
                        state_d   = land_play_q ? ST_PLAYING : ST_PAUSED;
                        tick_emit = 1'b1;
                    end else begin
                        seek_cnt_d = seek_cnt_q + 8'd1;
                    end
                end
                ST_PLAYING: begin
                    tick_emit = 1'b1;
                    if (cur_q >= LEADOUT_MSF) begin
                        state_d = ST_STOPPED;
                    end else begin
                        cur_d = cur_inc;
                        if (cur_inc >= LEADOUT_MSF) state_d = ST_STOPPED;
                    end
                end
                default: ;
            endcase
            // While a TOC reply is owed, ticks only move the position so the
            // reply keeps its slot in the status stream.
            if (tick_emit && !toc_req_q) begin
                vld_p1_d  = 1'b1;
                stat_p1_d = pack_status(state_d, 4'h0, cur_d, 4'h0);
            end
        end
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_STOPPED;
            cur_q       <= '0;
            seek_cnt_q  <= '0;
            land_play_q <= 1'b0;
            toc_req_q   <= 1'b0;
            toc_track_q <= '0;
            vld_p1      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            seek_cnt_q  <= seek_cnt_d;
            land_play_q <= land_play_d;
            toc_req_q   <= toc_req_d;
            toc_track_q <= toc_track_d;
            vld_p1      <= vld_p1_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        stat_p1 <= stat_p1_d;
    end

    // ---- stage p2: checksum and latch ----
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            vld_p2     <= 1'b0;
            STATUS_OUT <= 40'hF000000000;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) STATUS_OUT <= {chk_nib(stat_p1), stat_p1};
        end
    end

    assign STATUS_LATCH = vld_p2;
    assign TOC_REQ      = toc_req_q;
    assign TOC_TRACK    = toc_track_q;
    assign CUR_MSF      = cur_q;
    assign PLAYING      = (state_q == ST_PLAYING);

endmodule

// File: tb/tb_cd_cdd_core.sv
module tb_cd_cdd_core;

    localparam int CLK_HZ      = 1500;   // 20 clocks per frame
    localparam int SEEK_FRAMES = 8;

    logic        clk_sys = 1'b0;
    logic        RESET;
    logic [39:0] COMMAND_DATA;
    logic        COMMAND_SEND;
    logic [39:0] STATUS_OUT;
    logic        STATUS_LATCH;
    logic [7:0]  TOC_FIRST;
    logic [7:0]  TOC_LAST;
    logic [23:0] LEADOUT_MSF;
    logic        TOC_REQ;
    logic [7:0]  TOC_TRACK;
    logic        TOC_ACK;
    logic [23:0] TOC_START_MSF;
    logic [3:0]  TOC_TYPE;
    logic [23:0] CUR_MSF;
    logic        PLAYING;

    cd_cdd_core #(.CLK_HZ(CLK_HZ), .SEEK_FRAMES(SEEK_FRAMES)) dut (
        .clk_sys      (clk_sys),
        .RESET        (RESET),
        .COMMAND_DATA (COMMAND_DATA),
        .COMMAND_SEND (COMMAND_SEND),
        .STATUS_OUT   (STATUS_OUT),
        .STATUS_LATCH (STATUS_LATCH),
        .TOC_FIRST    (TOC_FIRST),
        .TOC_LAST     (TOC_LAST),
        .LEADOUT_MSF  (LEADOUT_MSF),
        .TOC_REQ      (TOC_REQ),
        .TOC_TRACK    (TOC_TRACK),
        .TOC_ACK      (TOC_ACK),
        .TOC_START_MSF(TOC_START_MSF),
        .TOC_TYPE     (TOC_TYPE),
        .CUR_MSF      (CUR_MSF),
        .PLAYING      (PLAYING)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int n_latch = 0;
    int last_latch = 0;

    logic [39:0] exp_q[$];
    int          exp_cyc_q[$];

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_status(input logic [39:0] s, input int c);
        exp_q.push_back(s);
        exp_cyc_q.push_back(c);
    endtask

    // Status word built nibble by nibble, checksum as 15 - (sum mod 16).
    function automatic logic [39:0] tb_pack(input int code, input int rpt,
                                            input logic [23:0] msf, input int flags);
        int nib[10];
        int sum;
        logic [39:0] r;
        nib[0] = code; nib[1] = rpt;
        nib[2] = int'(msf[23:20]); nib[3] = int'(msf[19:16]);
        nib[4] = int'(msf[15:12]); nib[5] = int'(msf[11:8]);
        nib[6] = int'(msf[7:4]);   nib[7] = int'(msf[3:0]);
        nib[8] = flags;
        sum = 0;
        for (int i = 0; i < 9; i++) sum += nib[i];
        nib[9] = 15 - (sum % 16);
        r = '0;
        for (int i = 0; i < 10; i++) r[4*i +: 4] = 4'(nib[i]);
        return r;
    endfunction

    // Frame-count based increment, independent of digit carries.
    function automatic logic [23:0] tb_inc(input logic [23:0] m);
        int mm, ss, ff, t;
        mm = int'(m[23:20]) * 10 + int'(m[19:16]);
        ss = int'(m[15:12]) * 10 + int'(m[11:8]);
        ff = int'(m[7:4]) * 10 + int'(m[3:0]);
        t  = ((mm * 60 + ss) * 75 + ff + 1) % (100 * 60 * 75);
        ff = t % 75; ss = (t / 75) % 60; mm = t / 4500;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(ff / 10), 4'(ff % 10)};
    endfunction

    // Scoreboard monitor: every latch must match the oldest outstanding expectation.
    always @(negedge clk_sys) begin
        logic [39:0] e;
        int          ec;
        if (!RESET && STATUS_LATCH) begin
            n_latch++;
            last_latch = cyc;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_latch: got status %h at cycle %0d, required no latch", STATUS_OUT, cyc);
            end else begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                chk("status", STATUS_OUT, e);
                if (ec >= 0) chk("latch_cycle", 40'(cyc), 40'(ec));
            end
        end
    end

    task automatic send_cmd(input logic [39:0] f);
        COMMAND_DATA = f;
        COMMAND_SEND = 1'b1;
        @(negedge clk_sys);
        COMMAND_SEND = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d statuses outstanding, required 0", exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    initial begin
        logic [23:0] m;
        int          base;
        int          nl;

        RESET = 1'b1;
        COMMAND_DATA = '0; COMMAND_SEND = 1'b0;
        TOC_FIRST = 8'h01; TOC_LAST = 8'h12; LEADOUT_MSF = 24'h743000;
        TOC_ACK = 1'b0; TOC_START_MSF = '0; TOC_TYPE = '0;
        repeat (3) @(negedge clk_sys);

        // Reset values
        chk("rst_status", STATUS_OUT, 40'hF000000000);
        chk("rst_latch", 40'(STATUS_LATCH), 40'h0);
        chk("rst_toc_req", 40'(TOC_REQ), 40'h0);
        chk("rst_playing", 40'(PLAYING), 40'h0);
        chk("rst_cur", 40'(CUR_MSF), 40'h0);
        chk("rst_track", 40'(TOC_TRACK), 40'h0);
        RESET = 1'b0;
        repeat (2) @(negedge clk_sys);

        // Good NOP, bad-checksum NOP
        expect_status(40'hF000000000, cyc + 3);
        send_cmd(40'hF000000000);
        wait_drain(20);
        expect_status(40'hE100000000, cyc + 3);
        send_cmd(40'h0000000000);
        wait_drain(20);

        // TOC 4 and TOC 3
        expect_status(40'h7000211040, cyc + 3);
        send_cmd(40'h9000000042);
        wait_drain(20);
        expect_status(40'hE000034730, cyc + 3);
        send_cmd(40'hA000000032);
        wait_drain(20);

        // Stray ack with no request outstanding
        nl = n_latch;
        TOC_ACK = 1'b1;
        @(negedge clk_sys);
        TOC_ACK = 1'b0;
        repeat (6) @(negedge clk_sys);
        chk("stray_ack_latches", 40'(n_latch), 40'(nl));

        // TOC 5 handshake
        base = cyc;
        send_cmd(40'h5000003052);
        chk("toc_req_c1", 40'(TOC_REQ), 40'h0);
        @(negedge clk_sys);
        chk("toc_req_c2", 40'(TOC_REQ), 40'h1);
        chk("toc_track", 40'(TOC_TRACK), 40'h03);
        repeat (10) @(negedge clk_sys);
        send_cmd(40'hF000000000);              // ignored during the wait
        repeat (86) @(negedge clk_sys);
        chk("toc_track_hold", 40'(TOC_TRACK), 40'h03);
        TOC_ACK = 1'b1; TOC_START_MSF = 24'h123456; TOC_TYPE = 4'h4;
        expect_status(40'h1465432150, cyc + 2);
        @(negedge clk_sys);
        TOC_ACK = 1'b0;
        chk("toc_req_drop", 40'(TOC_REQ), 40'h0);
        wait_drain(20);

        // PLAY 00:02:00: seek 8 frames, then 75 played frames
        m = 24'h000200;
        expect_status(40'hB000200002, cyc + 3);
        expect_status(40'hC000200001, -1);
        for (int i = 0; i < 75; i++) begin
            m = tb_inc(m);
            expect_status(tb_pack(1, 0, m, 0), -1);
        end
        send_cmd(40'hA000200003);
        wait_drain(20 * 90);
        chk("play_cur", 40'(CUR_MSF), 40'h000300);
        chk("play_playing", 40'(PLAYING), 40'h1);

        // Command on the same cycle as a frame tick
        base = last_latch;
        while (cyc < base + 18) @(negedge clk_sys);
        expect_status(40'hB000300001, base + 21);
        expect_status(40'hA010300001, base + 24);
        send_cmd(40'hF000000000);
        wait_drain(20);

        // PAUSE holds the position
        expect_status(40'h7010300004, cyc + 3);
        send_cmd(40'h9000000006);
        wait_drain(20);
        chk("pause_playing", 40'(PLAYING), 40'h0);
        repeat (45) @(negedge clk_sys);
        chk("pause_cur", 40'(CUR_MSF), 40'h000301);

        // Lead-out stop
        LEADOUT_MSF = 24'h010000;
        expect_status(40'h4047950002, cyc + 3);
        expect_status(40'h5047950001, -1);
        expect_status(40'hE000001000, -1);
        send_cmd(40'h3047950003);
        wait_drain(20 * 12);
        chk("leadout_cur", 40'(CUR_MSF), 40'h010000);
        chk("leadout_playing", 40'(PLAYING), 40'h0);
        repeat (45) @(negedge clk_sys);
        chk("leadout_hold", 40'(CUR_MSF), 40'h010000);

        // OPEN / CLOSE
        expect_status(40'h9000001005, cyc + 3);
        send_cmd(40'h200000000D);
        wait_drain(20);
        expect_status(40'hE000001000, cyc + 3);
        send_cmd(40'h300000000C);
        wait_drain(20);

        // Back-to-back: the second command is dropped
        expect_status(40'hE000001000, cyc + 3);
        send_cmd(40'hF000000000);
        send_cmd(40'hE000000001);
        wait_drain(20);
        repeat (5) @(negedge clk_sys);
        chk("busy_drop_cur", 40'(CUR_MSF), 40'h010000);

        // STOP clears the position
        expect_status(40'hF000000000, cyc + 3);
        send_cmd(40'hE000000001);
        wait_drain(20);
        chk("stop_cur", 40'(CUR_MSF), 40'h0);

        // Reset during a TOC wait
        send_cmd(40'h5000003052);
        repeat (3) @(negedge clk_sys);
        chk("toc_req_before_rst", 40'(TOC_REQ), 40'h1);
        RESET = 1'b1;
        #1;
        chk("toc_req_async_rst", 40'(TOC_REQ), 40'h0);
        @(negedge clk_sys);
        chk("rst2_status", STATUS_OUT, 40'hF000000000);
        chk("rst2_track", 40'(TOC_TRACK), 40'h0);
        RESET = 1'b0;
        repeat (4) @(negedge clk_sys);
        chk("leftover_expect", 40'(exp_q.size()), 40'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cd_cdd_core.md
# cd_cdd_core

Command interpreter and status generator behind the CDD 4-bit bus engine. It consumes each 10-nibble command frame captured from the host and validates its checksum. It runs the drive state machine and the BCD MSF play position at 75 frames/s, and answers TOC queries from static disc info or through a request/ack handshake to the image loader. Each result is packed into a 10-nibble status word that the bus engine sends on the next IRQ.

## Interface
- CLK_HZ, 48000000: clk_sys frequency. Frame divider terminal count = CLK_HZ/75 - 1.
- SEEK_FRAMES, 8: frame ticks spent in SEEKING before landing.
- clk_sys  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- COMMAND_DATA  in  40  command frame; nibble n = bits [4n+3:4n]
- COMMAND_SEND  in  1  one-cycle strobe, COMMAND_DATA valid
- STATUS_OUT  out  40  status frame, same nibble packing
- STATUS_LATCH  out  1  one-cycle strobe, STATUS_OUT updated
- TOC_FIRST, TOC_LAST  in  8  BCD first/last track
- LEADOUT_MSF  in  24  BCD {M,S,F} lead-out / disc length
- TOC_REQ  out  1  level; track start requested
- TOC_TRACK  out  8  BCD track number for TOC_REQ
- TOC_ACK  in  1  one-cycle strobe, TOC_START_MSF/TOC_TYPE valid
- TOC_START_MSF  in  24  BCD {M,S,F} track start
- TOC_TYPE  in  4  track type (0 audio, 4 data)
- CUR_MSF  out  24  BCD absolute position
- PLAYING  out  1  high in PLAYING state

## Operation
- Nibble map, both directions:
  - n0 = code.
  - n1 = report/sub-command.
  - n2..n7 = M tens, M units, S tens, S units, F tens, F units.
  - n8 = flags/type.
  - n9 = checksum.
- Checksum = ~(sum of n0..n8) mod 16.
- Bad command checksum: discard command, no state change. Emit status with current state and n8 bit0 = 1.
- Commands (n0):
  - 0 NOP: status only.
  - 1 STOP: go to STOPPED, CUR_MSF = 0.
  - 2 TOC: answer query, state unchanged.
  - 3 PLAY: target = n2..n7, go to SEEKING, land in PLAYING.
  - 4 SEEK: same as PLAY but land in PAUSED.
  - 6 PAUSE: PLAYING goes to PAUSED.
  - 7 RESUME: PAUSED goes to PLAYING.
  - 12 CLOSE: TRAY_OPEN goes to STOPPED.
  - 13 OPEN: go to TRAY_OPEN.
  - Other codes: NOP.
- States and status codes: STOPPED 0, PLAYING 1, SEEKING 2, PAUSED 4, TRAY_OPEN 5.
- SEEKING: CUR_MSF = target on entry. Leave after SEEK_FRAMES ticks.
- PLAYING frame tick, BCD increment:
  - F 74 wraps to 00 and carries into S.
  - S 59 wraps to 00 and carries into M.
  - M 99 wraps to 00.
  - When CUR_MSF >= LEADOUT_MSF, go to STOPPED and hold position.
- TOC sub-commands (n1):
  - 3: n2..n7 = LEADOUT_MSF.
  - 4: n2..n3 = TOC_FIRST, n4..n5 = TOC_LAST.
  - 5: TOC_TRACK = n2..n3, raise TOC_REQ, wait for TOC_ACK. Then n2..n7 = TOC_START_MSF, n8 = TOC_TYPE.
  - Other sub-commands: n1 echoed, n2..n8 = 0.
- Non-TOC status: n1 = 0 and n2..n7 = CUR_MSF.
- While PLAYING, every frame tick also rebuilds status and pulses STATUS_LATCH.

## Timing
- Reset values:
  - STATUS_OUT = 0xF000000000: STOPPED, all zero, checksum F.
  - STATUS_LATCH, TOC_REQ, PLAYING = 0.
  - TOC_TRACK, CUR_MSF = 0.
  - Divider, seek counter and pending flags = 0.
- Latency: COMMAND_SEND at cycle 0 gives STATUS_LATCH at cycle 3. Registers are decode, then state/pack, then checksum/latch.
- TOC 5 latency:
  - TOC_REQ rises at cycle 2, TOC_TRACK is stable while it is high.
  - TOC_ACK at cycle k drops TOC_REQ at k+1 and gives STATUS_LATCH at k+2.
  - Frame ticks keep advancing the position during the wait.
- COMMAND_SEND while busy (pipeline or TOC wait): ignored.
- TOC_ACK with TOC_REQ low: ignored.
- Frame tick and COMMAND_SEND in the same cycle: command goes first. The tick is held pending and applied one cycle after the command's STATUS_LATCH. At most one tick is pending.
- STATUS_LATCH is one cycle wide, at most one per 3 cycles. STATUS_OUT is stable from the latch until the next latch.
- RESET mid-TOC-wait: TOC_REQ drops immediately (asynchronous).

## Test plan
- Reset, then NOP with checksum F (frame 0xF000000000): STATUS_LATCH at +3, STATUS_OUT = 0xF000000000.
- Same NOP with checksum nibble 0: status n8 = 1, n9 = E, state stays STOPPED.
- PLAY 00:02:00, SEEK_FRAMES = 8:
  - Status code 2.
  - After 8 ticks, PLAYING = 1.
  - After 75 more ticks, CUR_MSF = 0x000300.
  - One STATUS_LATCH per tick.
- TOC 4 with TOC_FIRST = 0x01, TOC_LAST = 0x12: n2..n5 = 0,1,1,2, n1 = 4.
- TOC 5 for track 0x03:
  - TOC_REQ high with TOC_TRACK = 0x03.
  - ACK after 100 cycles with 0x123456, type 4.
  - Status n2..n8 = 1,2,3,4,5,6,4, latched at ACK+2.
- Play from 0x005974 with LEADOUT = 0x010000:
  - Tick 1: CUR_MSF = 0x010000, state goes to STOPPED.
  - COMMAND_SEND coincident with a tick: tick applied after the command's latch.
